// File: rtl/ex_stage_pkg.sv
// Shared widths, stall encoding, mult/div function codes and the decode-to-execute bus layout.
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 159;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_RF_WD  = 38;
  localparam int STALL_BUS_WD = 6;
  localparam int DIV_CYCLES   = 32;

  localparam int STALL_EX  = 2;
  localparam int STALL_MEM = 3;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_RUN,
    DIV_DONE
  } div_state_t;

  typedef struct packed {
    logic op_add;
    logic op_sub;
    logic op_slt;
    logic op_sltu;
    logic op_and;
    logic op_nor;
    logic op_or;
    logic op_xor;
    logic op_sll;
    logic op_srl;
    logic op_sra;
    logic op_lui;
  } alu_op_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    alu_op_t     alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
  } id_ex_t;

  // Two's-complement negate when neg is set; used for operand magnitudes and result signs.
  function automatic logic [31:0] cond_neg(input logic [31:0] val, input logic neg);
    return neg ? (~val + 32'd1) : val;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider, one quotient bit per cycle, signed or unsigned.
// Busy from the start cycle through the last iteration; holds the result in DONE while EX is stopped.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        stall_ex,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rem_q, rem_d;
  logic [31:0]       quo_q, quo_d;
  logic [31:0]       dvs_q, dvs_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic [32:0]       trial;
  logic [32:0]       diff;

  // Quotient register doubles as the dividend shift register.
  assign trial = {rem_q, quo_q[31]};
  assign diff  = trial - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        if (start) begin
          busy    = 1'b1;
          quo_d   = cond_neg(dividend, signed_op & dividend[31]);
          dvs_d   = cond_neg(divisor, signed_op & divisor[31]);
          rem_d   = '0;
          cnt_d   = '0;
          neg_q_d = signed_op & (dividend[31] ^ divisor[31]);
          neg_r_d = signed_op & dividend[31];
          state_d = DIV_RUN;
        end
      end
      DIV_RUN: begin
        busy = 1'b1;
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_CYCLES - 1)) begin
          state_d = DIV_DONE;
        end
      end
      DIV_DONE: begin
        done = 1'b1;
        if (stall_ex == NO_STOP) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
    end
  end

  // A zero divisor falls out naturally: all-ones magnitude quotient, dividend as remainder.
  assign quotient  = cond_neg(quo_q, neg_q_q);
  assign remainder = cond_neg(rem_q, neg_r_q);

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: registered decode bus, ALU, data-SRAM request, forwarding and HI/LO writes.
// Single-cycle except div/divu, which hold the pipeline via stallreq_for_ex for 33 cycles.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_BUS_WD-1:0] stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic [1:0]              hilo_we,
  output logic [31:0]             hi_wdata,
  output logic [31:0]             lo_wdata,
  output logic                    stallreq_for_ex
);

  id_ex_t      id_ex_q, id_ex_d;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] ex_result;
  logic [15:0] imm;
  logic [5:0]  func;
  logic        op_special;
  logic        is_mult, is_multu, is_div, is_divu;
  logic [63:0] prod_s, prod_u;
  logic        div_busy, div_done;
  logic [31:0] div_quo, div_rem;
  logic        unused_bits;

  always_comb begin
    id_ex_d = id_ex_q;
    if (stall[STALL_EX] == STOP && stall[STALL_MEM] == NO_STOP) begin
      id_ex_d = '0;
    end else if (stall[STALL_EX] == NO_STOP) begin
      id_ex_d = id_ex_t'(id_to_ex_bus);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign imm        = id_ex_q.inst[15:0];
  assign func       = id_ex_q.inst[5:0];
  assign op_special = (id_ex_q.inst[31:26] == 6'b000000);

  always_comb begin
    src1 = id_ex_q.rdata1;
    if (id_ex_q.sel_src1[1]) begin
      src1 = id_ex_q.pc;
    end else if (id_ex_q.sel_src1[2]) begin
      src1 = {27'b0, id_ex_q.inst[10:6]};
    end
  end

  always_comb begin
    src2 = id_ex_q.rdata2;
    if (id_ex_q.sel_src2[1]) begin
      src2 = {{16{imm[15]}}, imm};
    end else if (id_ex_q.sel_src2[2]) begin
      src2 = 32'd8;
    end else if (id_ex_q.sel_src2[3]) begin
      src2 = {16'b0, imm};
    end
  end

  // alu_op is one-hot, so OR-ing the gated results selects exactly one of them.
  always_comb begin
    ex_result = '0;
    if (id_ex_q.alu_op.op_add)  ex_result |= src1 + src2;
    if (id_ex_q.alu_op.op_sub)  ex_result |= src1 - src2;
    if (id_ex_q.alu_op.op_slt)  ex_result |= {31'b0, $signed(src1) < $signed(src2)};
    if (id_ex_q.alu_op.op_sltu) ex_result |= {31'b0, src1 < src2};
    if (id_ex_q.alu_op.op_and)  ex_result |= src1 & src2;
    if (id_ex_q.alu_op.op_nor)  ex_result |= ~(src1 | src2);
    if (id_ex_q.alu_op.op_or)   ex_result |= src1 | src2;
    if (id_ex_q.alu_op.op_xor)  ex_result |= src1 ^ src2;
    if (id_ex_q.alu_op.op_sll)  ex_result |= src2 << src1[4:0];
    if (id_ex_q.alu_op.op_srl)  ex_result |= src2 >> src1[4:0];
    if (id_ex_q.alu_op.op_sra)  ex_result |= $unsigned($signed(src2) >>> src1[4:0]);
    if (id_ex_q.alu_op.op_lui)  ex_result |= {src2[15:0], 16'b0};
  end

  assign ex_to_mem_bus = {id_ex_q.pc, id_ex_q.ram_en, id_ex_q.ram_wen, id_ex_q.sel_rf_res,
                          id_ex_q.rf_we, id_ex_q.rf_waddr, ex_result};
  assign ex_to_rf_bus  = {id_ex_q.rf_we, id_ex_q.rf_waddr, ex_result};

  assign data_sram_en    = id_ex_q.ram_en;
  assign data_sram_wen   = id_ex_q.ram_wen;
  assign data_sram_addr  = ex_result;
  assign data_sram_wdata = id_ex_q.rdata2;

  assign is_mult  = op_special && (func == FUNC_MULT);
  assign is_multu = op_special && (func == FUNC_MULTU);
  assign is_div   = op_special && (func == FUNC_DIV);
  assign is_divu  = op_special && (func == FUNC_DIVU);

  // Low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product.
  assign prod_s = {{32{id_ex_q.rdata1[31]}}, id_ex_q.rdata1} * {{32{id_ex_q.rdata2[31]}}, id_ex_q.rdata2};
  assign prod_u = {32'b0, id_ex_q.rdata1} * {32'b0, id_ex_q.rdata2};

  div_unit u_div_unit (
    .clk       (clk),
    .rst       (rst),
    .start     (is_div | is_divu),
    .signed_op (is_div),
    .dividend  (id_ex_q.rdata1),
    .divisor   (id_ex_q.rdata2),
    .stall_ex  (stall[STALL_EX]),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  assign stallreq_for_ex = div_busy;

  always_comb begin
    hilo_we  = 2'b00;
    hi_wdata = '0;
    lo_wdata = '0;
    if (div_done) begin
      hilo_we  = 2'b11;
      hi_wdata = div_rem;
      lo_wdata = div_quo;
    end else if (is_mult) begin
      hilo_we  = 2'b11;
      hi_wdata = prod_s[63:32];
      lo_wdata = prod_s[31:0];
    end else if (is_multu) begin
      hilo_we  = 2'b11;
      hi_wdata = prod_u[63:32];
      lo_wdata = prod_u[31:0];
    end
  end

  assign unused_bits = ^{stall[5:4], stall[1:0], id_ex_q.sel_src1[0], id_ex_q.sel_src2[0],
                         id_ex_q.inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Randomised self-checking bench for ex_stage against a behavioural model of ALU, mult and div.
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [5:0]   stall_force;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic [1:0]   hilo_we;
  logic [31:0]  hi_wdata;
  logic [31:0]  lo_wdata;
  logic         stallreq_for_ex;

  int checks;
  int failures;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .hilo_we         (hilo_we),
    .hi_wdata        (hi_wdata),
    .lo_wdata        (lo_wdata),
    .stallreq_for_ex (stallreq_for_ex)
  );

  // Stall controller stand-in: a busy EX stops PC/IF/ID/EX.
  assign stall = stall_force | (stallreq_for_ex ? 6'b001111 : 6'b000000);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                      input logic [11:0] op, input logic [2:0] s1,
                                      input logic [3:0] s2, input logic ren,
                                      input logic [3:0] wen, input logic we,
                                      input logic [4:0] wa, input logic srr,
                                      input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, ren, wen, we, wa, srr, r1, r2};
  endfunction

  function automatic logic [31:0] md_inst(input logic [5:0] func);
    return {6'b000000, 5'd1, 5'd2, 10'd0, func};
  endfunction

  // ALU reference, indexed by one-hot position: 11 add ... 0 lui.
  function automatic logic [31:0] alu_model(input int k, input logic [31:0] a, input logic [31:0] b);
    int          sa_i, sb_i;
    int unsigned sh;
    sa_i = a;
    sb_i = b;
    sh   = a % 32;
    case (k)
      11: return a + b;
      10: return a - b;
      9:  return (sa_i < sb_i) ? 32'd1 : 32'd0;
      8:  return (a < b) ? 32'd1 : 32'd0;
      7:  return a & b;
      6:  return ~(a | b);
      5:  return a | b;
      4:  return a ^ b;
      3:  return b << sh;
      2:  return b >> sh;
      1:  return (b >> sh) | ((b[31] == 1'b1) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      0:  return (b % 65536) * 65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int q_i, r_i;
    if (!sgn) begin
      if (b == 0) return {a, 32'hFFFF_FFFF};
      return {a % b, a / b};
    end
    if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    q_i = $signed(a) / $signed(b);
    r_i = $signed(a) % $signed(b);
    return {r_i, q_i};
  endfunction

  function automatic logic [63:0] mult_model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint p;
    if (sgn) begin
      p = longint'($signed(a)) * longint'($signed(b));
      return p;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Called at a negedge; the following posedge loads bus into EX, then the bench returns at the next negedge.
  task automatic issue(input logic [158:0] bus);
    id_to_ex_bus = bus;
    @(negedge clk);
    id_to_ex_bus = '0;
  endtask

  task automatic alu_expect(input string tag, input logic [158:0] bus, input logic [31:0] res);
    logic [75:0] mem_exp;
    mem_exp = {bus[158:127], bus[75], bus[74:71], bus[64], bus[70], bus[69:65], res};
    issue(bus);
    check_val({tag, "_mem"}, ex_to_mem_bus, mem_exp);
    check_val({tag, "_rf"}, ex_to_rf_bus, {bus[70], bus[69:65], res});
    check_val({tag, "_sram"}, {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
              {bus[75], bus[74:71], res, bus[31:0]});
    check_val({tag, "_hilo_we"}, hilo_we, 2'b00);
  endtask

  // Entered at a negedge with a div already in EX; returns at the DONE negedge.
  task automatic div_run(input string tag, input logic [63:0] exp_hilo, input logic [158:0] next_bus);
    int n;
    id_to_ex_bus = next_bus;
    n = 0;
    while (stallreq_for_ex === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check_val({tag, "_stall_cycles"}, n, 33);
    check_val({tag, "_hilo_we"}, hilo_we, 2'b11);
    check_val({tag, "_hi"}, hi_wdata, exp_hilo[63:32]);
    check_val({tag, "_lo"}, lo_wdata, exp_hilo[31:0]);
  endtask

  task automatic mult_check(input string tag, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = mult_model(sgn, a, b);
    issue(mk(32'h0040_0000, md_inst(sgn ? 6'b011000 : 6'b011001), 12'h000, 3'b001, 4'b0001,
             1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b));
    check_val({tag, "_hilo_we"}, hilo_we, 2'b11);
    check_val({tag, "_hi"}, hi_wdata, p[63:32]);
    check_val({tag, "_lo"}, lo_wdata, p[31:0]);
    check_val({tag, "_nostall"}, stallreq_for_ex, 1'b0);
  endtask

  function automatic logic [158:0] div_bus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    return mk(32'h0040_0100, md_inst(sgn ? 6'b011010 : 6'b011011), 12'h000, 3'b001, 4'b0001,
              1'b0, 4'h0, 1'b0, 5'd0, 1'b0, a, b);
  endfunction

  logic [158:0] addiu_bus;

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    stall_force  = 6'b000000;
    id_to_ex_bus = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_mem", ex_to_mem_bus, 76'd0);
    check_val("rst_rf", ex_to_rf_bus, 38'd0);
    check_val("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, 69'd0);
    check_val("rst_hilo", {hilo_we, hi_wdata, lo_wdata}, 66'd0);
    check_val("rst_stallreq", stallreq_for_ex, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Directed ALU cases.
    addiu_bus = mk(32'h0040_0010, {6'b001001, 5'd3, 5'd9, 16'hFFFF}, 12'h800, 3'b001, 4'b0010,
                   1'b0, 4'h0, 1'b1, 5'd9, 1'b0, 32'd5, 32'd0);
    alu_expect("addiu", addiu_bus, 32'd4);
    alu_expect("lui", mk(32'h0040_0014, {6'b001111, 5'd0, 5'd4, 16'h1234}, 12'h001, 3'b001, 4'b1000,
                         1'b0, 4'h0, 1'b1, 5'd4, 1'b0, 32'd0, 32'd0), 32'h1234_0000);
    alu_expect("ori", mk(32'h0040_0018, {6'b001101, 5'd2, 5'd5, 16'hF0F0}, 12'h020, 3'b001, 4'b1000,
                         1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h0F0F_0000, 32'd0), 32'h0F0F_F0F0);
    alu_expect("sw", mk(32'h0040_001C, {6'b101011, 5'd2, 5'd5, 16'hFFFC}, 12'h800, 3'b001, 4'b0010,
                        1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h1000_0010, 32'hCAFE_BABE), 32'h1000_000C);
    alu_expect("zero_op", mk(32'h0040_0020, 32'h2400_0000, 12'h000, 3'b001, 4'b0001,
                             1'b0, 4'h0, 1'b1, 5'd7, 1'b0, 32'h1234, 32'h5678), 32'd0);

    // Randomised ALU traffic.
    for (int i = 0; i < 40; i++) begin
      int          k, c1, c2;
      logic [31:0] pc, inst, r1, r2, a, b;
      logic [2:0]  s1;
      logic [3:0]  s2;
      logic [11:0] op;
      logic [15:0] imm;
      k    = $urandom_range(0, 11);
      c1   = $urandom_range(0, 2);
      c2   = $urandom_range(0, 3);
      pc   = $urandom;
      inst = {6'b001001, 26'($urandom)};
      r1   = $urandom;
      r2   = $urandom;
      op   = 12'd1 << k;
      s1   = 3'd1 << c1;
      s2   = 4'd1 << c2;
      imm  = inst[15:0];
      a    = (c1 == 1) ? pc : (c1 == 2) ? 32'(inst[10:6]) : r1;
      b    = (c2 == 1) ? 32'($signed(imm)) : (c2 == 2) ? 32'd8 : (c2 == 3) ? 32'(imm) : r2;
      alu_expect($sformatf("alu%0d_k%0d", i, k),
                 mk(pc, inst, op, s1, s2, 1'($urandom), 4'($urandom), 1'($urandom), 5'($urandom),
                    1'($urandom), r1, r2), alu_model(k, a, b));
    end

    // Multiply, directed then random.
    mult_check("mult", 1'b1, 32'hFFFF_FFFF, 32'd2);
    mult_check("multu", 1'b0, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < 8; i++) begin
      mult_check($sformatf("mul%0d", i), 1'($urandom), $urandom, $urandom);
    end

    // Divide: back-to-back chain of directed cases.
    issue(div_bus(1'b0, 32'd100, 32'd7));
    div_run("divu_100_7", div_model(1'b0, 32'd100, 32'd7), div_bus(1'b1, -32'sd7, 32'd2));
    @(negedge clk);
    div_run("div_m7_2", div_model(1'b1, -32'sd7, 32'd2), div_bus(1'b1, -32'sd5, 32'd0));
    @(negedge clk);
    div_run("div_m5_0", {-32'sd5, 32'd1}, div_bus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF));
    @(negedge clk);
    div_run("div_ovf", {32'd0, 32'h8000_0000}, div_bus(1'b0, 32'h1234_5678, 32'd0));
    @(negedge clk);
    div_run("divu_by0", {32'h1234_5678, 32'hFFFF_FFFF}, '0);
    @(negedge clk);
    check_val("div_after_hilo_we", hilo_we, 2'b00);
    check_val("div_after_stallreq", stallreq_for_ex, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic        sgn;
      logic [31:0] a, b;
      sgn = 1'($urandom);
      a   = $urandom;
      b   = (i == 3) ? 32'd0 : ($urandom_range(0, 1) == 1 ? 32'($urandom_range(1, 300)) : $urandom);
      issue(div_bus(sgn, a, b));
      div_run($sformatf("rdiv%0d", i), div_model(sgn, a, b), '0);
      @(negedge clk);
    end

    // EX register hold and bubble.
    alu_expect("pre_hold", addiu_bus, 32'd4);
    stall_force  = 6'b001111;
    id_to_ex_bus = mk(32'h0, 32'h3C00_5555, 12'h001, 3'b001, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd1,
                      1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check_val("hold_rf", ex_to_rf_bus, {1'b1, 5'd9, 32'd4});
    stall_force = 6'b000111;
    @(negedge clk);
    check_val("bubble_mem", ex_to_mem_bus, 76'd0);
    check_val("bubble_rf", ex_to_rf_bus, 38'd0);
    stall_force  = 6'b000000;
    id_to_ex_bus = '0;
    @(negedge clk);

    // Reset in the middle of a division.
    issue(div_bus(1'b0, 32'd1000, 32'd3));
    repeat (11) @(negedge clk);
    check_val("mid_div_busy", stallreq_for_ex, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_div_stallreq", stallreq_for_ex, 1'b0);
    check_val("rst_div_hilo_we", hilo_we, 2'b00);
    check_val("rst_div_mem", ex_to_mem_bus, 76'd0);
    rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_stallreq", stallreq_for_ex, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
